// File: rtl/mips_pkg.sv
// Shared ExtOp codes, beat record and encoder state for the immediate encoder.
package mips_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN        = 2'b00,
        EXT_ZERO        = 2'b01,
        EXT_HIGH        = 2'b10,
        EXT_SIGN_LEFT_2 = 2'b11
    } extop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT1 = 2'b01,
        ST_BEAT2 = 2'b10
    } enc_state_e;

    typedef struct packed {
        logic [15:0] imm;
        extop_e      ext;
    } beat_t;

endpackage

// File: rtl/imm_classify.sv
// Combinational split of a 32-bit constant (or branch offset) into one or two
// immediate beats. Branch encoding exists only with IMM_ENCODER_BRANCH_EN.
module imm_classify
    import mips_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic        i_branch,
    output logic        o_two,
    output beat_t       o_beat1,
    output beat_t       o_beat2,
    output logic        o_err
);

    logic w_sign_fit;
    logic w_zero_fit;
    logic w_high_fit;

    assign w_sign_fit = (&i_value[31:15]) | ~(|i_value[31:15]);
    assign w_zero_fit = ~(|i_value[31:16]);
    assign w_high_fit = ~(|i_value[15:0]);

`ifdef IMM_ENCODER_BRANCH_EN
    logic w_br_fit;
    // Word-aligned offset whose 18-bit signed value survives the >>2 shift
    assign w_br_fit = ~(|i_value[1:0]) & ((&i_value[31:17]) | ~(|i_value[31:17]));
`else
    logic w_unused_branch;
    assign w_unused_branch = i_branch;
`endif

    always_comb begin
        o_two   = 1'b0;
        o_err   = 1'b0;
        o_beat1 = '{imm: i_value[15:0], ext: EXT_SIGN};
        o_beat2 = '{imm: i_value[15:0], ext: EXT_ZERO};
`ifdef IMM_ENCODER_BRANCH_EN
        if (i_branch) begin
            o_beat1.ext = EXT_SIGN_LEFT_2;
            if (w_br_fit) begin
                o_beat1.imm = i_value[17:2];
            end else begin
                o_beat1.imm = 16'h0000;
                o_err       = 1'b1;
            end
        end else
`endif
        begin
            if (w_sign_fit) begin
                o_beat1.ext = EXT_SIGN;
            end else if (w_zero_fit) begin
                o_beat1.ext = EXT_ZERO;
            end else if (w_high_fit) begin
                o_beat1 = '{imm: i_value[31:16], ext: EXT_HIGH};
            end else begin
                o_two   = 1'b1;
                o_beat1 = '{imm: i_value[31:16], ext: EXT_HIGH};
            end
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: accepts one constant, emits it as one or two ExtOp beats.
// Optional branch-offset encoding enabled by IMM_ENCODER_BRANCH_EN.
module imm_encoder
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic        in_branch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm16,
    output logic [1:0]  out_extop,
    output logic        out_last,
    output logic        out_err
);

    enc_state_e r_state;
    enc_state_e w_next;
    logic [31:0] r_value;
    logic        r_branch;
    logic        w_two;
    logic        w_err;
    beat_t       w_beat1;
    beat_t       w_beat2;

    imm_classify u_classify (
        .i_value  (r_value),
        .i_branch (r_branch),
        .o_two    (w_two),
        .o_beat1  (w_beat1),
        .o_beat2  (w_beat2),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_value  <= '0;
            r_branch <= 1'b0;
        end else begin
            r_state <= w_next;
            if (in_valid && in_ready) begin
                r_value  <= in_value;
                r_branch <= in_branch;
            end
        end
    end

    // Beat fields are decoded from the held request, so they stay put while stalled
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_imm16 = 16'h0000;
        out_extop = EXT_SIGN;
        out_last  = 1'b0;
        out_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_BEAT1;
            end
            ST_BEAT1: begin
                out_valid = 1'b1;
                out_imm16 = w_beat1.imm;
                out_extop = w_beat1.ext;
                out_last  = ~w_two;
                out_err   = w_err;
                if (out_ready) w_next = w_two ? ST_BEAT2 : ST_IDLE;
            end
            ST_BEAT2: begin
                out_valid = 1'b1;
                out_imm16 = w_beat2.imm;
                out_extop = w_beat2.ext;
                out_last  = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench: queue-of-beats reference model compared every cycle.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = '0;
    logic        in_branch = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_imm16;
    logic [1:0]  out_extop;
    logic        out_last;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int vcyc = 0;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_branch (in_branch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm16 (out_imm16),
        .out_extop (out_extop),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  ext;
        logic        last;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mb0, mb1;
    int   mn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference rules in plain signed/unsigned arithmetic
    function automatic int model(input logic [31:0] v, input logic br,
                                 output exp_t b0, output exp_t b1);
        int signed sv;
        logic unused_br;
        sv = v;
        unused_br = br;
        b0 = '{imm: 16'h0, ext: 2'b00, last: 1'b1, err: 1'b0};
        b1 = b0;
`ifdef IMM_ENCODER_BRANCH_EN
        if (br) begin
            b0.ext = 2'b11;
            if ((v % 4 == 0) && sv >= -131072 && sv <= 131071)
                b0.imm = 16'(sv / 4);
            else
                b0.err = 1'b1;
            return 1;
        end
`endif
        if (sv >= -32768 && sv <= 32767) begin
            b0.imm = 16'(v); b0.ext = 2'b00; return 1;
        end
        if (v < 32'h10000) begin
            b0.imm = 16'(v); b0.ext = 2'b01; return 1;
        end
        if (v % 32'h10000 == 0) begin
            b0.imm = 16'(v / 32'h10000); b0.ext = 2'b10; return 1;
        end
        b0 = '{imm: 16'(v / 32'h10000), ext: 2'b10, last: 1'b0, err: 1'b0};
        b1 = '{imm: 16'(v % 32'h10000), ext: 2'b01, last: 1'b1, err: 1'b0};
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (out_ready) void'(q.pop_front());
        end else if (in_valid) begin
            mn = model(in_value, in_branch, mb0, mb1);
            q.push_back(mb0);
            if (mn == 2) q.push_back(mb1);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {10'b0, in_ready, out_valid, out_imm16, out_extop, out_last, out_err},
                {10'b0, 1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0});
        end else begin
            chk("in_ready", in_ready, q.size() == 0);
            chk("out_valid", out_valid, q.size() != 0);
            if (out_valid) vcyc++;
            if (out_valid && q.size() != 0)
                chk("beat", {out_imm16, out_extop, out_last, out_err}, q[0]);
        end
    end

    task automatic pin(input string nm, input logic [31:0] v, input logic br,
                       input int en, input exp_t e0, input exp_t e1);
        exp_t b0, b1;
        int n;
        n = model(v, br, b0, b1);
        chk({nm, "_n"}, n, en);
        chk({nm, "_b0"}, b0, e0);
        if (en == 2) chk({nm, "_b1"}, b1, e1);
    endtask

    task automatic send(input logic [31:0] v, input logic br);
        int a0, n;
        a0 = acc_cnt;
        n = 0;
        in_value = v; in_branch = br; in_valid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (acc_cnt == a0 && n < 50);
        if (acc_cnt == a0) chk("send_timeout", acc_cnt, a0 + 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0) chk("idle_timeout", q.size(), 0);
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 6)
            0: return r;
            1: return 32'($urandom_range(0, 65535)) - 32'd32768;
            2: return {r[31:16], 16'h0};
            3: return {16'h0, r[15:0]};
            4: return {{14{r[31]}}, r[17:2], 2'b00} + 32'($urandom % 4);
            default: begin
                case ($urandom % 6)
                    0: return 32'h0000_7FFF;
                    1: return 32'hFFFF_8000;
                    2: return 32'h0000_8000;
                    3: return 32'h8000_0000;
                    4: return 32'hFFFF_7FFF;
                    default: return 32'h0001_0000;
                endcase
            end
        endcase
    endfunction

    initial begin
        int a_prev;
        // Pin the reference model with hand-worked cases
        pin("m_1234",     32'h0000_1234, 1'b0, 1, {16'h1234, 2'b00, 1'b1, 1'b0}, '0);
        pin("m_12345678", 32'h1234_5678, 1'b0, 2, {16'h1234, 2'b10, 1'b0, 1'b0}, {16'h5678, 2'b01, 1'b1, 1'b0});
        pin("m_0",        32'h0000_0000, 1'b0, 1, {16'h0000, 2'b00, 1'b1, 1'b0}, '0);
        pin("m_7fff",     32'h0000_7FFF, 1'b0, 1, {16'h7FFF, 2'b00, 1'b1, 1'b0}, '0);
        pin("m_ffff8000", 32'hFFFF_8000, 1'b0, 1, {16'h8000, 2'b00, 1'b1, 1'b0}, '0);
        pin("m_8000",     32'h0000_8000, 1'b0, 1, {16'h8000, 2'b01, 1'b1, 1'b0}, '0);
        pin("m_80000000", 32'h8000_0000, 1'b0, 1, {16'h8000, 2'b10, 1'b1, 1'b0}, '0);
        pin("m_ffff0000", 32'hFFFF_0000, 1'b0, 1, {16'hFFFF, 2'b10, 1'b1, 1'b0}, '0);
`ifdef IMM_ENCODER_BRANCH_EN
        pin("m_br_fff8",  32'hFFFF_FFF8, 1'b1, 1, {16'hFFFE, 2'b11, 1'b1, 1'b0}, '0);
        pin("m_br_6",     32'h0000_0006, 1'b1, 1, {16'h0000, 2'b11, 1'b1, 1'b1}, '0);
`else
        pin("m_nobr_6",   32'h0000_0006, 1'b1, 1, {16'h0006, 2'b00, 1'b1, 1'b0}, '0);
`endif

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(32'h0000_1234, 1'b0); wait_idle();
        send(32'h1234_5678, 1'b0); wait_idle();
        send(32'hFFFF_0000, 1'b0);
        send(32'hFFFF_8000, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'h0000_7FFF, 1'b0);
        send(32'h0000_8000, 1'b0);
        send(32'h8000_0000, 1'b0);
        wait_idle();

        // Stall: beat must be presented for exactly 4 cycles
        out_ready = 1'b0;
        vcyc = 0;
        send(32'h0000_ABCD, 1'b0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        chk("stall_cycles", vcyc, 4);

        send(32'hFFFF_FFF8, 1'b1);
        send(32'h0000_0006, 1'b1);
        wait_idle();

        // Reset while BEAT2 is pending
        send(32'h1234_5678, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        a_prev = acc_cnt;
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom % 4) != 0;
            if (!in_valid || acc_cnt != a_prev) begin
                a_prev    = acc_cnt;
                in_valid  = $urandom % 2;
                in_value  = gen();
                in_branch = $urandom % 2;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameters: none; all widths fixed by the ISA.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  constant request present.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 in_value  input  32  constant, or byte offset when in_branch=1.
REQ-007 in_branch  input  1  1 = encode as branch offset.
REQ-008 out_valid  output  1  immediate beat present.
REQ-009 out_ready  input  1  consumer accepts beat.
REQ-010 out_imm16  output  16  immediate field.
REQ-011 out_extop  output  2  extension code: 00 sign, 01 zero, 10 high, 11 sign_left_2.
REQ-012 out_last  output  1  final beat of this constant.
REQ-013 out_err  output  1  offset not encodable; beat carries imm 0.

Function
REQ-014 FSM states: IDLE, BEAT1, BEAT2; in_ready SHALL equal (state==IDLE).
REQ-015 A request is accepted on in_valid&&in_ready; in_value and in_branch are registered and the state moves to BEAT1; out_valid SHALL be asserted the following cycle (latency 1).
REQ-016 A beat completes on out_valid&&out_ready; out_imm16/out_extop/out_last/out_err SHALL hold stable while out_valid&&!out_ready.
REQ-017 Non-branch classification, first match wins: in_value[31:15] all equal -> one beat sign, imm=[15:0]; [31:16]==0 -> one beat zero, imm=[15:0]; [15:0]==0 -> one beat high, imm=[31:16]; otherwise two beats.
REQ-018 Two-beat case: BEAT1 emits high, imm=[31:16], out_last=0; on completion go to BEAT2; BEAT2 emits zero, imm=[15:0], out_last=1.
REQ-019 Branch case: [1:0]==0 and [31:17] all equal -> one beat sign_left_2, imm=[17:2], out_err=0; otherwise one beat sign_left_2, imm=0, out_err=1.
REQ-020 Single-beat outputs SHALL have out_last=1; completion of a beat with out_last=1 returns to IDLE, so in_ready rises the next cycle.
REQ-021 Sustained throughput: one single-beat constant every 2 cycles; one two-beat constant every 3 cycles with out_ready tied high.
REQ-022 in_valid while in_ready=0 is ignored; the upstream holds the request.
REQ-023 Boundaries: 0x00000000 -> sign,0x0000; 0x00007FFF -> sign; 0xFFFF8000 -> sign,0x8000; 0x00008000 -> zero,0x8000; 0x80000000 -> high,0x8000.

Reset
REQ-024 While rst_n=0: state=IDLE, out_valid=0, out_imm16=0, out_extop=00, out_last=0, out_err=0, in_ready=1.
REQ-025 Reset asserted mid-operation SHALL discard any pending beat or BEAT2 without emitting it.

Configuration
REQ-026 Macro IMM_ENCODER_BRANCH_EN defined: branch encoding per REQ-019.
REQ-027 Macro IMM_ENCODER_BRANCH_EN undefined: in_branch is ignored, every request follows REQ-017, and out_err is tied 0.

Structure
REQ-028 Shared package mips_pkg SHALL hold the ExtOp codes (EXT_SIGN, EXT_ZERO, EXT_HIGH, EXT_SIGN_LEFT_2) and the encoder state enum.
REQ-029 One combinational sub-module, imm_classify, SHALL map (value, branch) to (beat count, beat-1 fields, beat-2 fields, err).

Verification
REQ-030 Request in_value=0x00001234, out_ready=1 -> one beat: sign, 0x1234, last=1, one cycle after acceptance.
REQ-031 Request 0x12345678 -> beats (high,0x1234,last=0) then (zero,0x5678,last=1); in_ready=0 until after beat 2.
REQ-032 Request 0x0000ABCD with out_ready=0 for 3 cycles -> zero,0xABCD held stable for 4 cycles, accepted on cycle 4.
REQ-033 With BRANCH_EN: in_branch=1, 0xFFFFFFF8 -> sign_left_2,0xFFFE; 0x00000006 -> err=1, imm=0.
REQ-034 Request 0x12345678; assert rst_n=0 after beat 1 -> no beat 2; after release: out_valid=0, in_ready=1.
REQ-035 Request 0xFFFF0000 -> one beat high,0xFFFF; request 0xFFFF8000 -> one beat sign,0x8000.
